// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier arbiter slice.
//   N_DEF     default operand width (signed two's complement)
//   NREQ_DEF  default number of requesters
//   LAT_DEF   default compute wait, in cycles, after the multiplier start pulse
//   state_t   arbiter FSM state encoding
//   id_width  width of a requester index
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam int N_DEF    = 9;
    localparam int NREQ_DEF = 4;
    localparam int LAT_DEF  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/radix8_booth_multiplier.sv
// ---------------------------------------------------------------------------
// radix8_booth_multiplier
// Signed N x N multiplier using radix-8 Booth recoding of the multiplier b.
// Each 4-bit overlapping window of b selects one of 0, +-a, +-2a, +-3a, +-4a;
// the partial products are summed and registered into Prod.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous clear of Prod (held high for one cycle per start)
//   a      in   N-bit signed multiplicand, held stable for the operation
//   b      in   N-bit signed multiplier, held stable for the operation
//   Prod   out  2N-bit signed product, valid one cycle after reset falls
// ---------------------------------------------------------------------------
module radix8_booth_multiplier
    import booth_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] Prod
);

    localparam int ND = (N + 2) / 3;   // number of radix-8 digits
    localparam int BW = 3 * ND;        // b sign-extended to a whole number of digits
    localparam int PW = 2 * N;

    logic [BW:0]   w_b_ext;
    logic [PW-1:0] w_a1;
    logic [PW-1:0] w_a2;
    logic [PW-1:0] w_a3;
    logic [PW-1:0] w_a4;
    logic [3:0]    w_win;
    logic [PW-1:0] w_pp;
    logic [PW-1:0] w_sum;

    // Implicit zero below the LSB starts the first Booth window.
    assign w_b_ext = {BW'(signed'(b)), 1'b0};

    assign w_a1 = PW'(signed'(a));
    assign w_a2 = w_a1 << 1;
    assign w_a3 = w_a1 + w_a2;         // the one "hard" multiple of radix-8
    assign w_a4 = w_a1 << 2;

    // Sum is modulo 2^PW; the true product always fits, so wrap-around
    // of intermediate partial products is harmless.
    always_comb begin
        w_sum = '0;
        w_win = '0;
        w_pp  = '0;
        for (int k = 0; k < ND; k++) begin
            w_win = w_b_ext[3*k +: 4];
            case (w_win)
                4'b0001, 4'b0010: w_pp = w_a1;
                4'b0011, 4'b0100: w_pp = w_a2;
                4'b0101, 4'b0110: w_pp = w_a3;
                4'b0111:          w_pp = w_a4;
                4'b1000:          w_pp = -w_a4;
                4'b1001, 4'b1010: w_pp = -w_a3;
                4'b1011, 4'b1100: w_pp = -w_a2;
                4'b1101, 4'b1110: w_pp = -w_a1;
                default:          w_pp = '0;
            endcase
            w_sum = w_sum + (w_pp << (3 * k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Prod <= '0;
        end else begin
            Prod <= w_sum;
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
// Round-robin scheduler sharing one radix-8 Booth multiplier between NREQ
// requesters. One operation is in flight at a time: grant, one-cycle start
// pulse, LAT-cycle compute wait, then a held response until consumed.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester request valid
//   req_a      in   [NREQ*N]   multiplicands, requester i at [i*N +: N]
//   req_b      in   [NREQ*N]   multipliers, same packing
//   req_ready  out  [NREQ]     one-hot grant (combinational, IDLE only)
//   rsp_valid  out             product available
//   rsp_prod   out  [2N]       signed product
//   rsp_id     out  [IDW]      owner of the product
//   rsp_ready  in              consumer accepts the response
//   busy       out             high whenever the FSM is not IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for any req_valid; grants round-robin winner
// S_START | multiplier held in reset with latched operands; load counter
// S_RUN   | multiplier computing; counter runs LAT-1 down to 0
// S_RESP  | product presented; waits for rsp_ready
// ---------------------------------------------------------------------------
module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter  int N    = N_DEF,
    parameter  int NREQ = NREQ_DEF,
    parameter  int LAT  = LAT_DEF,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [2*N-1:0]    rsp_prod,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int             CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(LAT - 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [IDW-1:0] r_last;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;

    logic           w_any;
    logic [IDW-1:0] w_grant;
    logic           w_mult_reset;
    logic [2*N-1:0] w_prod;

    // Priority runs last+1, last+2, ... wrapping, ending at last. Scanning
    // from the lowest-priority offset upward lets the highest-priority valid
    // requester overwrite the pick last.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        int             idx;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NREQ;
            if (valid[idx]) begin
                pick = IDW'(idx);
            end
        end
        return pick;
    endfunction

    assign w_any   = |req_valid;
    assign w_grant = rr_pick(req_valid, r_last);

    // Gated by reset_n so no grant is visible while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (reset_n && (r_state == S_IDLE) && w_any) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Multiplier is also held clear throughout a global reset.
    assign w_mult_reset = ~reset_n | (r_state == S_START);

    radix8_booth_multiplier #(
        .N (N)
    ) u_mult (
        .clk   (clk),
        .reset (w_mult_reset),
        .a     (r_a),
        .b     (r_b),
        .Prod  (w_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= CNT_LOAD;
            r_last    <= LAST_RST;
            r_a       <= '0;
            r_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= req_a[w_grant*N +: N];
                        r_b     <= req_b[w_grant*N +: N];
                        rsp_id  <= w_grant;
                        r_last  <= w_grant;
                        busy    <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        rsp_prod  <= w_prod;
                        rsp_valid <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
module tb_booth_mult_arbiter;

    localparam int N    = 9;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int IDW  = 2;
    localparam int PW   = 2 * N;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [PW-1:0]     rsp_prod;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int op_a [NREQ];
    int op_b [NREQ];

    always #5 clk = ~clk;

    booth_mult_arbiter #(
        .N    (N),
        .NREQ (NREQ),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [PW-1:0] ref_prod(input int a, input int b);
        return PW'(a * b);
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic int rand_op();
        if ($urandom_range(0, 15) == 0) return -256;
        if ($urandom_range(0, 15) == 0) return 255;
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = N'(op_a[i]);
            req_b[i*N +: N] = N'(op_b[i]);
        end
    endtask

    // Stimulus only: issue one request, wait for its grant and its response.
    task automatic run_op(input int id, input int a, input int b,
                          output logic [PW-1:0] prod, output logic [IDW-1:0] rid,
                          output int lat, output bit ok);
        ok = 1'b0; lat = 0; prod = '0; rid = '0;
        @(posedge clk); #1;
        op_a[id] = a; op_b[id] = b; drive_ops();
        req_valid[id] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[id] === 1'b1) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (!ok) return;
        ok = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1; lat = c; prod = rsp_prod; rid = rsp_id;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; rsp_ready = 1'b0; req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = rand_op(); op_b[i] = rand_op(); end
        drive_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_prod !== '0) begin errors++; $display("FAIL rst_rsp_prod: got %h want 0", rsp_prod); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        req_valid = '0; reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL rst_release_idle: busy=%b ready=%b want 0/0", busy, req_ready); end
    endtask

    task automatic test_single();
        logic exp_v;
        @(posedge clk); #1;
        op_a[0] = -7; op_b[0] = 13; drive_ops();
        req_valid = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_v = (k == 6);
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL single_rsp_valid_c%0d: got %b want %b", k, rsp_valid, exp_v); end
            if (k == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
            end
        end
        checks++; if (rsp_prod !== ref_prod(-91, 1)) begin errors++; $display("FAIL single_prod: got %h want %h", rsp_prod, ref_prod(-91, 1)); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_back_idle: busy=%b valid=%b want 0/0", busy, rsp_valid); end
    endtask

    task automatic test_corners();
        int ca [4];
        int cb [4];
        int ce [4];
        logic [PW-1:0] p; logic [IDW-1:0] id; int lat; bit ok;
        ca = '{-256, 255, 0, -1};
        cb = '{-256, -256, 123, -1};
        ce = '{65536, -65280, 0, 1};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(i % NREQ, ca[i], cb[i], p, id, lat, ok);
            checks++; if (!ok) begin errors++; $display("FAIL corner%0d_timeout: got none want response", i); end
            checks++; if (p !== PW'(ce[i])) begin errors++; $display("FAIL corner%0d_prod: got %h want %h", i, p, PW'(ce[i])); end
            checks++; if (id !== IDW'(i % NREQ)) begin errors++; $display("FAIL corner%0d_id: got %0d want %0d", i, id, i % NREQ); end
            checks++; if (lat !== LAT + 2) begin errors++; $display("FAIL corner%0d_latency: got %0d want %0d", i, lat, LAT + 2); end
        end
    endtask

    task automatic test_fairness();
        int q_id [$];
        logic [PW-1:0] q_prod [$];
        int grants, exp_g, last_gcyc, g_idx, eid;
        logic [NREQ-1:0] gnt;
        logic [PW-1:0] ep;
        @(posedge clk); #1;
        reset_n = 1'b0; #2; reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = rand_op(); op_b[i] = rand_op(); end
        drive_ops();
        req_valid = '1; rsp_ready = 1'b1;
        grants = 0; exp_g = 0; last_gcyc = 0; g_idx = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (q_id.size() == 0) begin
                    errors++; $display("FAIL fair_spurious_rsp: got id %0d want none", rsp_id);
                end else begin
                    eid = q_id.pop_front(); ep = q_prod.pop_front();
                    if (rsp_id !== IDW'(eid) || rsp_prod !== ep) begin
                        errors++; $display("FAIL fair_rsp: got id %0d prod %h want id %0d prod %h", rsp_id, rsp_prod, eid, ep);
                    end
                end
            end
            gnt = req_ready;
            if (gnt !== '0) begin
                checks++; if (gnt !== (NREQ'(1) << exp_g)) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", grants, gnt, NREQ'(1) << exp_g); end
                if (grants > 0) begin
                    checks++; if (cyc - last_gcyc != LAT + 3) begin errors++; $display("FAIL fair_period%0d: got %0d want %0d", grants, cyc - last_gcyc, LAT + 3); end
                end
                q_id.push_back(exp_g);
                q_prod.push_back(ref_prod(op_a[exp_g], op_b[exp_g]));
                last_gcyc = cyc; grants++; g_idx = exp_g;
                exp_g = (exp_g + 1) % NREQ;
            end
            @(posedge clk); #1;
            if (gnt !== '0) begin
                op_a[g_idx] = rand_op(); op_b[g_idx] = rand_op(); drive_ops();
            end
            if (grants == 8) begin req_valid = '0; break; end
        end
        checks++; if (grants != 8) begin errors++; $display("FAIL fair_grant_count: got %0d want 8", grants); end
        for (int c = 0; c < 20 && q_id.size() > 0; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                eid = q_id.pop_front(); ep = q_prod.pop_front();
                checks++;
                if (rsp_id !== IDW'(eid) || rsp_prod !== ep) begin
                    errors++; $display("FAIL fair_rsp_last: got id %0d prod %h want id %0d prod %h", rsp_id, rsp_prod, eid, ep);
                end
            end
        end
        checks++; if (q_id.size() != 0) begin errors++; $display("FAIL fair_missing_rsp: got %0d outstanding want 0", q_id.size()); end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp1, exp2;
        bit found;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        op_a[1] = rand_op(); op_b[1] = rand_op(); drive_ops();
        exp1 = ref_prod(op_a[1], op_b[1]);
        req_valid = 4'b0010;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[1] === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        @(posedge clk); #1;
        op_a[2] = rand_op(); op_b[2] = rand_op(); drive_ops();
        exp2 = ref_prod(op_a[2], op_b[2]);
        req_valid = 4'b0100;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin found = 1'b1; break; end
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_grant_while_busy: got %b want 0", req_ready); end
        end
        checks++; if (!found) begin errors++; $display("FAIL bp_rsp_timeout: got none want response"); end
        for (int s = 0; s < 10; s++) begin
            if (s > 0) @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stall%0d_valid: got %b want 1", s, rsp_valid); end
            checks++; if (rsp_prod !== exp1) begin errors++; $display("FAIL bp_stall%0d_prod: got %h want %h", s, rsp_prod, exp1); end
            checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_stall%0d_id: got %0d want 1", s, rsp_id); end
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_stall%0d_ready: got %b want 0", s, req_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_stall%0d_busy: got %b want 1", s, busy); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL bp_release: valid=%b ready=%b want 1/0", rsp_valid, req_ready); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%b valid=%b want 0/0", busy, rsp_valid); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found || rsp_prod !== exp2 || rsp_id !== 2'd2) begin
            errors++; $display("FAIL bp_second_rsp: got found=%b id %0d prod %h want id 2 prod %h", found, rsp_id, rsp_prod, exp2);
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] p, exp0, exp2; logic [IDW-1:0] id; int lat; bit ok; bit found;
        rsp_ready = 1'b1;
        run_op(0, 5, 7, p, id, lat, ok);
        checks++; if (!ok || p !== ref_prod(5, 7)) begin errors++; $display("FAIL mid_pre_op: got %h want %h", p, ref_prod(5, 7)); end
        @(posedge clk); #1;
        op_a[0] = rand_op(); op_b[0] = rand_op(); drive_ops();
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        op_a[0] = rand_op(); op_b[0] = rand_op();
        op_a[2] = rand_op(); op_b[2] = rand_op();
        drive_ops();
        exp0 = ref_prod(op_a[0], op_b[0]);
        exp2 = ref_prod(op_a[2], op_b[2]);
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_prod !== '0) begin errors++; $display("FAIL mid_rst_prod: got %h want 0", rsp_prod); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL mid_rst_id: got %0d want 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL mid_rst_hold: valid=%b ready=%b want 0/0", rsp_valid, req_ready); end
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        found = 1'b0; lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin found = 1'b1; lat = c; break; end
        end
        checks++; if (!found || lat != LAT + 2) begin errors++; $display("FAIL mid_rsp_latency: got %0d want %0d", lat, LAT + 2); end
        checks++; if (rsp_prod !== exp0 || rsp_id !== 2'd0) begin errors++; $display("FAIL mid_rsp0: got id %0d prod %h want id 0 prod %h", rsp_id, rsp_prod, exp0); end
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_second_grant: got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin found = 1'b1; break; end
        end
        checks++; if (!found || rsp_prod !== exp2 || rsp_id !== 2'd2) begin errors++; $display("FAIL mid_rsp2: got id %0d prod %h want id 2 prod %h", rsp_id, rsp_prod, exp2); end
    endtask

    task automatic test_random();
        int q_id [$];
        logic [PW-1:0] q_prod [$];
        logic [NREQ-1:0] vld, exp_rdy;
        logic exp_rv;
        logic [PW-1:0] ep;
        int eid, model_last, gcyc, g, cyc, n_raised, n_rsp;
        bit model_busy, do_grant, do_hs;
        @(posedge clk); #1;
        reset_n = 1'b0; #2; reset_n = 1'b1;
        req_valid = '0;
        vld = '0; model_last = NREQ - 1; model_busy = 1'b0; gcyc = 0; g = 0;
        n_raised = 0; n_rsp = 0; do_grant = 1'b0; do_hs = 1'b0; cyc = 0;
        while (n_rsp < 2000 && cyc < 60000) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (do_hs) model_busy = 1'b0;
            if (do_grant) begin
                model_busy = 1'b1; model_last = g; vld[g] = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!vld[i] && n_raised < 2000 && $urandom_range(0, 3) == 0) begin
                    op_a[i] = rand_op(); op_b[i] = rand_op();
                    vld[i] = 1'b1; n_raised++;
                end
            end
            drive_ops();
            req_valid = vld;
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            exp_rdy = '0; do_grant = 1'b0;
            if (!model_busy && vld != '0) begin
                g = rr_model(vld, model_last);
                exp_rdy = NREQ'(1) << g;
                do_grant = 1'b1;
            end
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            checks++; if (busy !== model_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, model_busy); end
            exp_rv = model_busy && (cyc - gcyc >= LAT + 2);
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, rsp_valid, exp_rv); end
            do_hs = exp_rv && rsp_ready;
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                checks++;
                if (q_id.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious_rsp@%0d: got id %0d want none", cyc, rsp_id);
                end else begin
                    eid = q_id.pop_front(); ep = q_prod.pop_front();
                    if (rsp_id !== IDW'(eid) || rsp_prod !== ep) begin
                        errors++; $display("FAIL rnd_rsp@%0d: got id %0d prod %h want id %0d prod %h", cyc, rsp_id, rsp_prod, eid, ep);
                    end
                end
                n_rsp++;
            end
            if (do_grant) begin
                gcyc = cyc;
                q_id.push_back(g);
                q_prod.push_back(ref_prod(op_a[g], op_b[g]));
            end
            cyc++;
        end
        checks++; if (n_rsp != 2000) begin errors++; $display("FAIL rnd_rsp_count: got %0d want 2000", n_rsp); end
        checks++; if (q_id.size() != 0) begin errors++; $display("FAIL rnd_outstanding: got %0d want 0", q_id.size()); end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_corners();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin scheduler that shares one `radix8_booth_multiplier` between `NREQ` requesters in the systolic matrix-multiply datapath. It accepts signed operand pairs over per-requester valid/ready handshakes and sequences the multiplier: a one-cycle start pulse, then a fixed compute wait. It returns each exact `2*N`-bit product, tagged with the requester ID, over a single valid/ready response channel. One operation is in flight at a time.

## Interface
- `N`, 9: operand width, signed two's complement.
- `NREQ`, 4: number of requesters, ≥2.
- `LAT`, 4: cycles from multiplier start-pulse release until `Prod` is valid, ≥1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_a` in NREQ*N: multiplicands; requester i occupies bits [i*N +: N].
- `req_b` in NREQ*N: multipliers, same packing as `req_a`.
- `req_ready` out NREQ: one-hot grant; the request is accepted when valid and ready are both high.
- `rsp_valid` out 1: product available.
- `rsp_prod` out 2*N: signed product.
- `rsp_id` out $clog2(NREQ): index of the requester that owns the product.
- `rsp_ready` in 1: consumer accepts the response.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE → START → RUN → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is high, grant the winner g by driving `req_ready[g]=1` combinationally in that cycle.
  - At the clock edge, latch `req_a[g]` and `req_b[g]` into the operand registers, latch g into the ID register, set `last=g`, and move to START.
  - With no valid requests, stay in IDLE and drive `req_ready=0`.
- **START** (1 cycle): drive the multiplier `reset=1` with the latched operands. Load the counter with `LAT-1`.
- **RUN** (`LAT` cycles)
  - Multiplier `reset=0`. Decrement the counter each cycle.
  - In the cycle where the counter equals 0, capture `Prod` into `rsp_prod` and move to RESP.
- **RESP**
  - Drive `rsp_valid=1`, holding `rsp_prod` and `rsp_id` stable.
  - On `rsp_ready=1`, move to IDLE. Otherwise hold.
  - No grants are issued while in RESP.
- **Round-robin arbitration**
  - Priority order is `last+1, last+2, …` wrapping modulo NREQ, ending at `last`.
  - `last` resets to NREQ-1, so requester 0 has top priority after reset.
- **Requester rule**: once `req_valid[i]` rises, it stays high with stable operands until accepted. Withdrawing before a grant is tolerated; no grant is issued for a withdrawn request.
- **Arithmetic**
  - Exact signed product, no rounding or saturation.
  - Full range is covered, for example (-2^(N-1))² = 2^(2N-2).
- **Multiplier reset**: the multiplier's `reset` input is driven as `~reset_n | (state==START)`. The multiplier is therefore also held clear during a global reset.
- **Reset (asynchronous, any state including mid-operation)**
  - State returns to IDLE. Any in-flight operation is dropped with no response.
  - Counter and `last=NREQ-1` are reloaded.
  - All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_prod`, `rsp_id`, `busy`.

## Timing
- Request accepted in cycle 0.
- START in cycle 1.
- RUN in cycles 2 to LAT+1; `Prod` is captured at the end of cycle LAT+1.
- `rsp_valid` rises in cycle LAT+2. This is 6 cycles with the default `LAT=4`.
- If `rsp_ready` is high in cycle LAT+2, the block is back in IDLE in cycle LAT+3, and the next grant can occur in that same cycle.
- Minimum request-to-request period is LAT+3 = 7 cycles.
- Back-pressure stretches RESP by one cycle per cycle of `rsp_ready=0`.
- `req_ready` is a combinational function of `req_valid`, state and `last`. All other outputs are registered.

## Structure
- Shared package `booth_pkg`:
  - Default `N`, `NREQ` and `LAT` constants.
  - FSM state typedef (IDLE, START, RUN, RESP).
  - ID width function `$clog2(NREQ)`.
- One sub-module: `radix8_booth_multiplier`, instantiated once with `#(N)`. Port connections are clk→`clk`, `reset`, `a`, `b` and `Prod`.
- The round-robin priority pick lives in this module as a function; no separate arbiter module is used.

## Test plan
- **Single request**: after reset, requester 0 sends a=-7, b=13. Expected: `req_ready[0]=1` in cycle 0; `rsp_valid=1` in cycle 6 with `rsp_prod=-91` and `rsp_id=0`.
- **Corner operands**, all with `rsp_ready=1`:
  - (-256, -256) → 65536
  - (255, -256) → -65280
  - (0, 123) → 0
  - (-1, -1) → 1
- **Fairness**: all four requesters hold `req_valid=1` and `rsp_ready=1`. Expected: grants go 0, 1, 2, 3, 0, … with one grant every 7 cycles, and `rsp_id` matches each grant.
- **Back-pressure**: hold `rsp_ready=0` for 10 cycles in RESP. Expected during the stall: `rsp_valid`, `rsp_prod` and `rsp_id` stay stable; `req_ready` stays 0; `busy` stays 1. Expected after release: IDLE and a new grant one cycle later.
- **Reset mid-operation**: drop `reset_n` in the 2nd RUN cycle. Expected:
  - All outputs go to 0 immediately and no response is produced.
  - After release, requesters 2 and 0 are both valid and requester 0 is granted first.
  - Requester 0's product is correct.
- **Random regression**: 2000 random operand pairs from random requesters with random `rsp_ready` stalls. Expected: every accepted request yields exactly one response, with `rsp_prod` equal to a*b and the correct `rsp_id`.
